// File: rtl/wallace_three_bit_multiplier_pkg.sv
// rtl/wallace_three_bit_multiplier_pkg.sv - shared widths for exact and approximate 3x3 multipliers
package wallace_three_bit_multiplier_pkg;

    localparam int OPERAND_W = 3;
    localparam int PRODUCT_W = 6;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - full adder cell
// Ports: a, b, cin -> sum, cout
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - half adder cell
// Ports: a, b -> sum, cout
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule

// File: rtl/wallace_three_bit_multiplier.sv
// rtl/wallace_three_bit_multiplier.sv - unsigned 3x3 Wallace-tree multiplier with registered product
// Ports:
//   clk   - clock, product captured on rising edge
//   rst_n - asynchronous active-low clear of the product register
//   in1   - unsigned multiplicand
//   in2   - unsigned multiplier
//   out   - registered product in1*in2
module wallace_three_bit_multiplier
    import wallace_three_bit_multiplier_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPERAND_W-1:0] in1,
    input  logic [OPERAND_W-1:0] in2,
    output logic [PRODUCT_W-1:0] out
);

    // pp[i][j] = in1[i] & in2[j], weight i+j
    logic [OPERAND_W-1:0] pp [OPERAND_W];

    always_comb begin
        for (int i = 0; i < OPERAND_W; i++) begin
            for (int j = 0; j < OPERAND_W; j++) begin
                pp[i][j] = in1[i] & in2[j];
            end
        end
    end

    // Stage 1: reduce every column to at most two bits
    logic s1_sum, s1_cy;   // column 1 half adder
    logic s2_sum, s2_cy;   // column 2 full adder
    logic s3_sum, s3_cy;   // column 3 half adder

    half_adder u_st1_c1 (.a(pp[1][0]), .b(pp[0][1]),                 .sum(s1_sum), .cout(s1_cy));
    full_adder u_st1_c2 (.a(pp[2][0]), .b(pp[1][1]), .cin(pp[0][2]), .sum(s2_sum), .cout(s2_cy));
    half_adder u_st1_c3 (.a(pp[2][1]), .b(pp[1][2]),                 .sum(s3_sum), .cout(s3_cy));

    // Final ripple adder over columns 2..4; column 1 holds a single bit
    // after stage 1 so it goes straight to the product.
    logic f2_sum, f2_cy;
    logic f3_sum, f3_cy;
    logic f4_sum, f4_cy;

    half_adder u_cpa_c2 (.a(s1_cy), .b(s2_sum),                  .sum(f2_sum), .cout(f2_cy));
    full_adder u_cpa_c3 (.a(s2_cy), .b(s3_sum),   .cin(f2_cy),   .sum(f3_sum), .cout(f3_cy));
    full_adder u_cpa_c4 (.a(s3_cy), .b(pp[2][2]), .cin(f3_cy),   .sum(f4_sum), .cout(f4_cy));

    logic [PRODUCT_W-1:0] product_d;
    logic [PRODUCT_W-1:0] product_q;

    assign product_d = {f4_cy, f4_sum, f3_sum, f2_sum, s1_sum, pp[0][0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= '0;
        end else begin
            product_q <= product_d;
        end
    end

    assign out = product_q;

endmodule

// File: tb/tb_wallace_three_bit_multiplier.sv
// tb/tb_wallace_three_bit_multiplier.sv - self-checking bench for wallace_three_bit_multiplier
module tb_wallace_three_bit_multiplier;

    logic       clk;
    logic       rst_n;
    logic [2:0] in1;
    logic [2:0] in2;
    logic [5:0] out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [$];

    wallace_three_bit_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (%b), expected %0d (%b) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Drive operands on the falling edge, sample 1ns after the capturing rising edge.
    task automatic apply(input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{a: 3'd0, b: 3'd7, exp: 6'd0,  name: "0x7"});
        vecs.push_back('{a: 3'd7, b: 3'd0, exp: 6'd0,  name: "7x0"});
        vecs.push_back('{a: 3'd1, b: 3'd7, exp: 6'd7,  name: "1x7"});
        vecs.push_back('{a: 3'd7, b: 3'd1, exp: 6'd7,  name: "7x1"});
        vecs.push_back('{a: 3'd7, b: 3'd7, exp: 6'b110001, name: "7x7"});
        vecs.push_back('{a: 3'd5, b: 3'd6, exp: 6'd30, name: "5x6"});
        vecs.push_back('{a: 3'd3, b: 3'd3, exp: 6'd9,  name: "3x3"});
        vecs.push_back('{a: 3'd6, b: 3'd6, exp: 6'd36, name: "6x6"});
        vecs.push_back('{a: 3'd4, b: 3'd4, exp: 6'd16, name: "4x4"});
        vecs.push_back('{a: 3'd2, b: 3'd5, exp: 6'd10, name: "2x5"});
        vecs.push_back('{a: 3'd7, b: 3'd6, exp: 6'd42, name: "7x6"});
        vecs.push_back('{a: 3'd3, b: 3'd5, exp: 6'd15, name: "3x5"});

        // Reset held with live operands across several edges
        rst_n = 1'b0;
        in1   = 3'b101;
        in2   = 3'b110;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", out, 6'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset_5x6", out, 6'd30);

        // Directed table
        foreach (vecs[k]) begin
            apply(vecs[k].a, vecs[k].b);
            check(vecs[k].name, out, vecs[k].exp);
        end

        // Back-to-back sweep of every operand pair
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                apply(3'(a), 3'(b));
                check($sformatf("sweep_%0dx%0d", a, b), out, 6'(a * b));
            end
        end

        // Asynchronous reset between edges while out=49
        apply(3'd7, 3'd7);
        check("pre_reset_49", out, 6'd49);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", out, 6'd0);
        @(posedge clk);
        #1;
        check("clear_held_over_edge", out, 6'd0);
        @(negedge clk);
        in1   = 3'd3;
        in2   = 3'd3;
        rst_n = 1'b1;
        #1;
        check("no_stale_after_release", out, 6'd0);
        @(posedge clk);
        #1;
        check("post_reset_3x3", out, 6'd9);

        // Constant operands: output must hold across edges
        apply(3'd6, 3'd5);
        check("hold_start", out, 6'd30);
        repeat (10) begin
            @(negedge clk);
            check("hold_negedge", out, 6'd30);
            @(posedge clk);
            #1;
            check("hold_posedge", out, 6'd30);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
